// File: rtl/ppc_isa_pkg.sv
// ============================================================================
// ppc_isa_pkg : uPower opcode / extended-opcode constants and decoded bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package ppc_isa_pkg;

  localparam logic [5:0] OP_X31   = 6'd31;
  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_XORI  = 6'd26;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LBZ   = 6'd34;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STWU  = 6'd37;
  localparam logic [5:0] OP_STB   = 6'd38;
  localparam logic [5:0] OP_LHZ   = 6'd40;
  localparam logic [5:0] OP_LHA   = 6'd42;
  localparam logic [5:0] OP_STH   = 6'd44;
  localparam logic [5:0] OP_B     = 6'd18;
  localparam logic [5:0] OP_BC    = 6'd19;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STD   = 6'd62;

  localparam logic [8:0] XO9_ADD  = 9'd266;
  localparam logic [8:0] XO9_SUBF = 9'd40;

  localparam logic [9:0] XO10_AND   = 10'd28;
  localparam logic [9:0] XO10_EXTSW = 10'd986;
  localparam logic [9:0] XO10_NAND  = 10'd476;
  localparam logic [9:0] XO10_OR    = 10'd444;
  localparam logic [9:0] XO10_XOR   = 10'd316;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [8:0]  xoxo;
    logic [9:0]  xox;
    logic        rc;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] si;
    logic [13:0] ds;
    logic [1:0]  xods;
    logic [23:0] li;
    logic        aa;
    logic        lk;
    logic        illegal;
  } dec_bundle_t;

  function automatic logic is_xo10_legal(input logic [9:0] xo);
    return xo inside {XO10_AND, XO10_EXTSW, XO10_NAND, XO10_OR, XO10_XOR};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppc_field_extract.sv
// ============================================================================
// ppc_field_extract : combinational instruction word -> decoded field bundle
// Rev 1.0
// ============================================================================
`default_nettype none

module ppc_field_extract
  import ppc_isa_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_bundle_t o_bundle
);

  logic [8:0]  w_xo9;
  logic [9:0]  w_xo10;
  logic        w_legal;
  dec_bundle_t w_raw;

  assign w_xo9  = i_instr[9:1];
  assign w_xo10 = i_instr[10:1];

  always_comb begin
    w_raw        = '0;
    w_legal      = 1'b0;
    w_raw.opcode = i_instr[31:26];
    w_raw.rt     = i_instr[25:21];
    w_raw.ra     = i_instr[20:16];
    w_raw.rb     = i_instr[15:11];
    w_raw.si     = i_instr[15:0];
    w_raw.ds     = i_instr[15:2];
    case (i_instr[31:26])
      OP_X31: begin
        w_raw.rc = i_instr[0];
        // XO-form claims the 9-bit field first; OE=1 is not supported
        if (w_xo9 == XO9_ADD || w_xo9 == XO9_SUBF) begin
          w_raw.xoxo = w_xo9;
          w_legal    = ~i_instr[10];
        end else begin
          w_raw.xox  = w_xo10;
          w_legal    = is_xo10_legal(w_xo10);
        end
      end
      OP_B: begin
        w_raw.li = i_instr[25:2];
        w_raw.aa = i_instr[1];
        w_raw.lk = i_instr[0];
        w_legal  = 1'b1;
      end
      OP_BC: begin
        w_raw.aa = i_instr[1];
        w_raw.lk = i_instr[0];
        w_legal  = 1'b1;
      end
      OP_LD, OP_STD: begin
        w_raw.xods = i_instr[1:0];
        w_legal    = (i_instr[1:0] != 2'b11);
      end
      OP_ADDI, OP_ADDIS, OP_ANDI, OP_ORI, OP_XORI,
      OP_LWZ, OP_LBZ, OP_STW, OP_STWU, OP_STB, OP_LHZ, OP_LHA, OP_STH: begin
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    if (w_legal) begin
      o_bundle = w_raw;
    end else begin
      o_bundle         = '0;
      o_bundle.opcode  = i_instr[31:26];
      o_bundle.illegal = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ppc_inst_decoder.sv
// ============================================================================
// ppc_inst_decoder : registered uPower decoder with one-entry skid buffer,
//                    flush, and saturating illegal-instruction counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ppc_inst_decoder
  import ppc_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       dec_opcode,
  output logic [8:0]       dec_xoxo,
  output logic [9:0]       dec_xox,
  output logic             dec_rc,
  output logic [4:0]       dec_rt,
  output logic [4:0]       dec_ra,
  output logic [4:0]       dec_rb,
  output logic [15:0]      dec_si,
  output logic [13:0]      dec_ds,
  output logic [1:0]       dec_xods,
  output logic [23:0]      dec_li,
  output logic             dec_aa,
  output logic             dec_lk,
  output logic             dec_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  dec_bundle_t      w_dec;
  dec_bundle_t      r_out;
  dec_bundle_t      r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_drain;

  ppc_field_extract u_extract (
    .i_instr  (in_instr),
    .o_bundle (w_dec)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_cnt        <= '0;
    end else begin
      if (w_drain && r_out.illegal && r_cnt != c_CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);

      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (!r_out_valid || w_drain) begin
        // in_ready is low whenever the skid is full, so no accept competes here
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept)
            r_out <= w_dec;
        end
      end else if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign illegal_cnt = r_cnt;
  assign dec_opcode  = r_out.opcode;
  assign dec_xoxo    = r_out.xoxo;
  assign dec_xox     = r_out.xox;
  assign dec_rc      = r_out.rc;
  assign dec_rt      = r_out.rt;
  assign dec_ra      = r_out.ra;
  assign dec_rb      = r_out.rb;
  assign dec_si      = r_out.si;
  assign dec_ds      = r_out.ds;
  assign dec_xods    = r_out.xods;
  assign dec_li      = r_out.li;
  assign dec_aa      = r_out.aa;
  assign dec_lk      = r_out.lk;
  assign dec_illegal = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ppc_inst_decoder.sv
// ============================================================================
// tb_ppc_inst_decoder : scoreboard bench for ppc_inst_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ppc_inst_decoder;
  import ppc_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  dec_opcode;
  logic [8:0]  dec_xoxo;
  logic [9:0]  dec_xox;
  logic        dec_rc;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_ra;
  logic [4:0]  dec_rb;
  logic [15:0] dec_si;
  logic [13:0] dec_ds;
  logic [1:0]  dec_xods;
  logic [23:0] dec_li;
  logic        dec_aa;
  logic        dec_lk;
  logic        dec_illegal;
  logic [15:0] illegal_cnt;

  dec_bundle_t q[$];
  dec_bundle_t act;
  int errors = 0;
  int checks = 0;

  ppc_inst_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .dec_opcode(dec_opcode), .dec_xoxo(dec_xoxo),
    .dec_xox(dec_xox), .dec_rc(dec_rc), .dec_rt(dec_rt), .dec_ra(dec_ra),
    .dec_rb(dec_rb), .dec_si(dec_si), .dec_ds(dec_ds), .dec_xods(dec_xods),
    .dec_li(dec_li), .dec_aa(dec_aa), .dec_lk(dec_lk),
    .dec_illegal(dec_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    act         = '0;
    act.opcode  = dec_opcode;
    act.xoxo    = dec_xoxo;
    act.xox     = dec_xox;
    act.rc      = dec_rc;
    act.rt      = dec_rt;
    act.ra      = dec_ra;
    act.rb      = dec_rb;
    act.si      = dec_si;
    act.ds      = dec_ds;
    act.xods    = dec_xods;
    act.li      = dec_li;
    act.aa      = dec_aa;
    act.lk      = dec_lk;
    act.illegal = dec_illegal;
  end

  // Monitor: every handshake on the output must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL deliver: unexpected word got=%h expected=none", act);
      end else begin
        dec_bundle_t e;
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL deliver: got=%h expected=%h", act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic dec_bundle_t ill(input logic [5:0] op);
    dec_bundle_t e;
    e = '0;
    e.opcode  = op;
    e.illegal = 1'b1;
    return e;
  endfunction

  function automatic dec_bundle_t mk_addi(input logic [4:0] rt, input logic [15:0] si,
                                          input logic [13:0] ds);
    dec_bundle_t e;
    e = '0;
    e.opcode = 6'd14;
    e.rt     = rt;
    e.si     = si;
    e.ds     = ds;
    return e;
  endfunction

  task automatic send(input logic [31:0] w, input dec_bundle_t e);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        done = 1;
      end else begin
        n++;
        if (n > 100) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready=%0b expected=1", in_ready);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_bundle_t e;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_cnt", illegal_cnt, 0);
    chk("reset_bundle", act, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Legal words across the forms
    e = '0; e.opcode = 31; e.xoxo = 266; e.rt = 3; e.ra = 4; e.rb = 5;
    e.si = 16'h2A14; e.ds = 14'h0A85;
    send(32'h7C642A14, e);
    chk("latency_valid", out_valid, 1);
    chk("latency_rt", dec_rt, 3);
    e = mk_addi(5'd1, 16'hFFFC, 14'h3FFF); e.ra = 2; e.rb = 31;
    send(32'h3822FFFC, e);
    e = '0; e.opcode = 58; e.rt = 5; e.ra = 6; e.si = 16'h0008; e.ds = 14'd2;
    send(32'hE8A60008, e);
    e = '0; e.opcode = 31; e.xox = 444; e.rt = 3; e.ra = 3; e.rb = 4;
    e.si = 16'h2378; e.ds = 14'h08DE;
    send(32'h7C632378, e);
    e = '0; e.opcode = 18; e.li = 24'd4; e.lk = 1'b1; e.si = 16'h0011; e.ds = 14'd4;
    send(32'h48000011, e);
    drain();
    chk("cnt_legal_only", illegal_cnt, 0);

    // Illegal words and counter saturation
    send(32'h00000000, ill(6'd0));
    send(32'h7C642E14, ill(6'd31));
    drain();
    chk("cnt_two", illegal_cnt, 2);
    send(32'hE8A6000B, ill(6'd58));
    drain();
    chk("cnt_three", illegal_cnt, 3);
    for (int i = 0; i < 65532; i++) send(32'h00000000, ill(6'd0));
    drain();
    chk("cnt_full", illegal_cnt, 16'hFFFF);
    send(32'h00000000, ill(6'd0));
    drain();
    chk("cnt_saturate", illegal_cnt, 16'hFFFF);

    // Backpressure through the skid buffer
    out_ready = 1'b0;
    fork
      begin
        send(32'h38200004, mk_addi(5'd1, 16'd4, 14'd1));
        send(32'h38400008, mk_addi(5'd2, 16'd8, 14'd2));
        send(32'h3860000C, mk_addi(5'd3, 16'd12, 14'd3));
        send(32'h38800010, mk_addi(5'd4, 16'd16, 14'd4));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_hold_rt", dec_rt, 1);
        chk("stall_hold_si", dec_si, 4);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with output and skid full
    out_ready = 1'b0;
    send(32'h38A00014, mk_addi(5'd5, 16'd20, 14'd5));
    send(32'h38C00018, mk_addi(5'd6, 16'd24, 14'd6));
    in_valid = 1'b1; in_instr = 32'h00000000; flush = 1'b1;
    q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt", illegal_cnt, 16'hFFFF);

    // Flush wins over a word that would otherwise be accepted
    send(32'h38E0001C, mk_addi(5'd7, 16'd28, 14'd7));
    in_valid = 1'b1; in_instr = 32'h3900FFFF; flush = 1'b1;
    q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h39200020, mk_addi(5'd9, 16'd32, 14'd8));
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h39400024, mk_addi(5'd10, 16'd36, 14'd9));
    send(32'h39600028, mk_addi(5'd11, 16'd40, 14'd10));
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h3980002C; out_ready = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    send(32'h39A00030, mk_addi(5'd13, 16'd48, 14'd12));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ppc_inst_decoder.md
Name: ppc_inst_decoder

Overview:
- Producer side of the ALU32bit operand-field interface.
- Accepts raw 32-bit uPower instruction words from fetch over a valid/ready handshake.
- Splits each word into the field bundle the ALU consumes (opcode, xoxo, xox, rc, ds, si, xods), plus register indices and branch fields.
- Flags illegal encodings and presents the result on a registered valid/ready output, with a skid buffer so in_ready is a flop.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch word valid
- in_ready  out  1  decoder can accept (registered)
- in_instr  in  32  instruction word, bit 31 = ISA bit 0
- flush  in  1  discard all held words
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- dec_opcode  out  6  instr[31:26]
- dec_xoxo  out  9  XO-form extended opcode, else 0
- dec_xox  out  10  X-form extended opcode, else 0
- dec_rc  out  1  instr[0] for opcode 31, else 0
- dec_rt  out  5  instr[25:21] (RT/RS/BO)
- dec_ra  out  5  instr[20:16] (RA/BI)
- dec_rb  out  5  instr[15:11]
- dec_si  out  16  instr[15:0] (SI/D/UI)
- dec_ds  out  14  instr[15:2] (DS/BD)
- dec_xods  out  2  instr[1:0] for opcodes 58/62, else 0
- dec_li  out  24  instr[25:2] for opcode 18, else 0
- dec_aa  out  1  instr[1] for opcodes 18/19, else 0
- dec_lk  out  1  instr[0] for opcodes 18/19, else 0
- dec_illegal  out  1  encoding not in legal set
- illegal_cnt  out  CNT_W  saturating count of illegal words delivered

Behaviour:
- Reset: all outputs 0, except in_ready = 1. Skid buffer is empty.
- Legal set, opcode 31:
  - XO-form when instr[9:1] ∈ {266, 40}: dec_xoxo = instr[9:1], dec_xox = 0. OE (instr[10]) = 1 is illegal.
  - Otherwise X-form: dec_xox = instr[10:1], which must be ∈ {28, 986, 476, 444, 316}; dec_xoxo = 0.
- Legal set, other opcodes: {14, 15, 28, 24, 26, 32, 34, 36, 37, 38, 40, 42, 44, 18, 19, 58, 62}.
- Opcodes 58/62 with xods = 3 are illegal. All other opcodes are illegal.
- Illegal word: dec_opcode keeps instr[31:26], dec_illegal = 1, every other dec_* field = 0. The word is still delivered.
- Latency: an accepted word appears on out_* the cycle after in_valid & in_ready.
- Throughput: 1 word/cycle while out_ready = 1.
- Output register: out_* hold stable while out_valid & !out_ready.
- out_valid never drops without out_ready or flush.
- Skid buffer: one entry.
  - If the output register is full, not drained, and a word is accepted, the decoded word goes to the skid entry and in_ready falls next cycle.
  - When the output drains, the skid entry moves to the output and in_ready rises next cycle.
- Simultaneous accept and drain with the skid empty: output reloads directly; the skid stays empty.
- Flush: next cycle out_valid = 0, skid empty, in_ready = 1. A word presented in the flush cycle is dropped.
- flush has priority over accept; illegal_cnt is unaffected.
- illegal_cnt increments on out_valid & out_ready & dec_illegal and saturates at all-ones.
- rst mid-stream returns to the reset state regardless of in_valid/out_ready.

Decomposition:
- Shared package ppc_isa_pkg holds:
  - opcode constants: OP_X31 = 31, OP_ADDI = 14, OP_ADDIS = 15, OP_ANDI = 28, OP_ORI = 24, OP_XORI = 26, loads/stores 32–44, OP_B = 18, OP_BC = 19, OP_LD = 58, OP_STD = 62
  - XO9 constants: ADD = 266, SUBF = 40
  - XO10 constants: AND = 28, EXTSW = 986, NAND = 476, OR = 444, XOR = 316
  - a packed struct for the decoded bundle
- Sub-module ppc_field_extract: purely combinational word→bundle+illegal. Instantiated once; the top holds the output register, skid entry, handshake and counter.

Test Plan:
- Reset, then 0x7C642A14 (add r3,r4,r5) with out_ready = 1 → next cycle out_valid = 1, opcode 31, xoxo 266, xox 0, rt 3, ra 4, rb 5, rc 0, illegal 0.
- 0x3822FFFC (addi r1,r2,-4) → opcode 14, rt 1, ra 2, si 0xFFFC, xoxo 0, xox 0; then 0xE8A60008 (ld r5,8(r6)) → opcode 58, rt 5, ra 6, ds 2, xods 0.
- 0x00000000, then 0x7C642E14 (add with OE = 1) → both illegal = 1, all other fields 0; illegal_cnt reaches 2; preset the counter to 0xFFFF via 65535 illegal words → the next illegal word leaves it at 0xFFFF.
- Stream 4 legal words with out_ready = 0 for 3 cycles → word 1 held on the output, word 2 in the skid, in_ready = 0; release → words 2, 3, 4 delivered in order, none lost or duplicated.
- Output and skid full, assert flush with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, the flush-cycle word is never delivered.
- Assert rst while out_valid = 1 and the skid is full → next cycle out_valid = 0, in_ready = 1, illegal_cnt = 0.
